multicycle_control: RTL and testbench

- Moore FSM sequencing the multicycle CPU datapath: fetch, decode, then a per-opcode execute/memory/writeback path.
- Drives all datapath mux selects and write enables from the current state only.
- Sits beside the datapath and takes the 6-bit opcode from the instruction register.

---
 rtl/multicycle_control_pkg.sv | 56 +++++
 rtl/multicycle_control.sv | 160 ++++++++++++++++
 tb/tb_multicycle_control.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle CPU controller: state enum, opcodes and
// datapath select values.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StJump   = 4'd2,
        StBranch = 4'd3,
        StAddiEx = 4'd4,
        StLuiEx  = 4'd5,
        StImmWb  = 4'd6,
        StREx    = 4'd7,
        StRWb    = 4'd8,
        StAddr   = 4'd9,
        StMemWr  = 4'd10,
        StMemRd  = 4'd11,
        StMemWb  = 4'd12
    } state_e;

    localparam logic [5:0] OpNoop = 6'b000000;
    localparam logic [5:0] OpJ    = 6'b000001;
    localparam logic [5:0] OpBeq  = 6'b100000;
    localparam logic [5:0] OpBne  = 6'b100001;
    localparam logic [5:0] OpBlt  = 6'b100010;
    localparam logic [5:0] OpAddi = 6'b110010;
    localparam logic [5:0] OpLui  = 6'b111010;
    localparam logic [5:0] OpAnd  = 6'b010101;
    localparam logic [5:0] OpSwi  = 6'b111100;
    localparam logic [5:0] OpSw   = 6'b111110;
    localparam logic [5:0] OpLwi  = 6'b111011;
    localparam logic [5:0] OpLw   = 6'b111101;
    // R-type is any opcode whose top three bits match this prefix
    localparam logic [2:0] OpRtypeHi = 3'b010;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpRtype = 2'b10;

    localparam logic [1:0] SrcAPc   = 2'b00;
    localparam logic [1:0] SrcAReg  = 2'b01;
    localparam logic [1:0] SrcAZero = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBOne   = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmHi = 2'b11;

    localparam logic [1:0] RegDstRd = 2'b00;
    localparam logic [1:0] RegDstRt = 2'b01;

endpackage

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle datapath: fetch, decode, then a per-opcode
// execute / memory / writeback path. Outputs depend on the current state only.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       Instr26,
    output logic       RegSelect1,
    output logic [1:0] RegSelect2
);

    state_e state_q, state_d;
    // Memory-op flavour captured in DECODE so later opcode changes are ignored
    logic   store_q, store_d;
    logic   imm_addr_q, imm_addr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StFetch;
            store_q    <= 1'b0;
            imm_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            imm_addr_q <= imm_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        imm_addr_d = imm_addr_q;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                state_d = StFetch;
                if (opcode[5:3] == OpRtypeHi) begin
                    state_d = StREx;
                end else begin
                    case (opcode)
                        OpJ:                 state_d = StJump;
                        OpBeq, OpBne, OpBlt: state_d = StBranch;
                        OpAddi:              state_d = StAddiEx;
                        OpLui:               state_d = StLuiEx;
                        OpSw, OpSwi: begin
                            state_d    = StAddr;
                            store_d    = 1'b1;
                            imm_addr_d = (opcode == OpSwi);
                        end
                        OpLw, OpLwi: begin
                            state_d    = StAddr;
                            store_d    = 1'b0;
                            imm_addr_d = (opcode == OpLwi);
                        end
                        default:             state_d = StFetch;
                    endcase
                end
            end
            StAddiEx: state_d = StImmWb;
            StLuiEx:  state_d = StImmWb;
            StREx:    state_d = StRWb;
            StAddr:   state_d = store_q ? StMemWr : StMemRd;
            StMemRd:  state_d = StMemWb;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = PcSrcAlu;
        ALUOp       = AluOpAdd;
        ALUSrcA     = SrcAPc;
        ALUSrcB     = SrcBReg;
        RegWrite    = 1'b0;
        Instr26     = 1'b0;
        RegSelect1  = 1'b0;
        RegSelect2  = RegDstRd;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    ALUSrcA  = SrcAPc;
                    ALUSrcB  = SrcBOne;
                    ALUOp    = AluOpAdd;
                    PCSource = PcSrcAlu;
                end
                StDecode: begin
                    ALUSrcA = SrcAPc;
                    ALUSrcB = SrcBImm;
                    ALUOp   = AluOpAdd;
                end
                StJump: begin
                    PCWrite  = 1'b1;
                    PCSource = PcSrcJump;
                    Instr26  = 1'b1;
                end
                StBranch: begin
                    ALUSrcA     = SrcAReg;
                    ALUSrcB     = SrcBReg;
                    ALUOp       = AluOpSub;
                    PCWriteCond = 1'b1;
                    PCSource    = PcSrcAluOut;
                end
                StAddiEx: begin
                    ALUSrcA = SrcAReg;
                    ALUSrcB = SrcBImm;
                end
                StLuiEx: begin
                    ALUSrcA = SrcAZero;
                    ALUSrcB = SrcBImmHi;
                end
                StImmWb: begin
                    RegWrite   = 1'b1;
                    RegSelect2 = RegDstRt;
                end
                StREx: begin
                    ALUSrcA = SrcAReg;
                    ALUSrcB = SrcBReg;
                    ALUOp   = AluOpRtype;
                end
                StRWb: begin
                    RegWrite   = 1'b1;
                    RegSelect2 = RegDstRd;
                end
                StAddr: begin
                    ALUSrcA = imm_addr_q ? SrcAZero : SrcAReg;
                    ALUSrcB = SrcBImm;
                end
                StMemWr: begin
                    MemWrite   = 1'b1;
                    RegSelect1 = 1'b1;
                end
                StMemWb: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    RegSelect2 = RegDstRt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control vectors are
// queued per instruction and compared on the falling clock edge.
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       PCWriteCond, PCWrite, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcA, ALUSrcB, RegSelect2;
    logic       RegWrite, Instr26, RegSelect1;

    int total = 0;
    int bad   = 0;

    logic [17:0] exp_q[$];
    logic [17:0] obs;

    always #5 clock = ~clock;

    multicycle_control dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .PCWriteCond (PCWriteCond),
        .PCWrite     (PCWrite),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .RegWrite    (RegWrite),
        .Instr26     (Instr26),
        .RegSelect1  (RegSelect1),
        .RegSelect2  (RegSelect2)
    );

    assign obs = {PCWriteCond, PCWrite, MemWrite, MemtoReg, IRWrite, PCSource, ALUOp,
                  ALUSrcA, ALUSrcB, RegWrite, Instr26, RegSelect1, RegSelect2};

    // Field order: pcwc pcw mw m2r ir pcsrc aluop srca srcb rw i26 rs1 rs2
    function automatic logic [17:0] mk(input logic pcwc, input logic pcw, input logic mw,
                                       input logic m2r, input logic ir,
                                       input logic [1:0] pcs, input logic [1:0] aop,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic rw, input logic i26, input logic rs1,
                                       input logic [1:0] rs2);
        return {pcwc, pcw, mw, m2r, ir, pcs, aop, sa, sb, rw, i26, rs1, rs2};
    endfunction

    logic [17:0] v_fetch, v_decode, v_jump, v_branch, v_addi, v_lui, v_immwb, v_rex, v_rwb;
    logic [17:0] v_addr_r, v_addr_i, v_memwr, v_memrd, v_memwb, v_zero;

    initial begin
        v_fetch  = mk(0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 2'b00);
        v_decode = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 0, 2'b00);
        v_jump   = mk(0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00);
        v_branch = mk(1, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 2'b00, 0, 0, 0, 2'b00);
        v_addi   = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 0, 0, 2'b00);
        v_lui    = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b11, 0, 0, 0, 2'b00);
        v_immwb  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01);
        v_rex    = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0, 2'b00);
        v_rwb    = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b00);
        v_addr_r = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 0, 0, 2'b00);
        v_addr_i = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 0, 0, 0, 2'b00);
        v_memwr  = mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00);
        v_memrd  = '0;
        v_memwb  = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01);
        v_zero   = '0;
    end

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", tag, got, want);
        end
    endtask

    // Reference sequence for one instruction, starting in FETCH
    task automatic push_expected(input logic [5:0] op);
        exp_q.push_back(v_fetch);
        exp_q.push_back(v_decode);
        if (op[5:3] == 3'b010) begin
            exp_q.push_back(v_rex);
            exp_q.push_back(v_rwb);
        end else begin
            case (op)
                6'b000001: exp_q.push_back(v_jump);
                6'b100000, 6'b100001, 6'b100010: exp_q.push_back(v_branch);
                6'b110010: begin exp_q.push_back(v_addi); exp_q.push_back(v_immwb); end
                6'b111010: begin exp_q.push_back(v_lui);  exp_q.push_back(v_immwb); end
                6'b111110: begin exp_q.push_back(v_addr_r); exp_q.push_back(v_memwr); end
                6'b111100: begin exp_q.push_back(v_addr_i); exp_q.push_back(v_memwr); end
                6'b111101: begin
                    exp_q.push_back(v_addr_r); exp_q.push_back(v_memrd);
                    exp_q.push_back(v_memwb);
                end
                6'b111011: begin
                    exp_q.push_back(v_addr_i); exp_q.push_back(v_memrd);
                    exp_q.push_back(v_memwb);
                end
                default: ;
            endcase
        end
    endtask

    // Entered #1 after a rising edge with the FSM in FETCH; leaves it the same way
    task automatic run_instr(input string name, input logic [5:0] op);
        int n = 0;
        opcode = op;
        push_expected(op);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            check_eq($sformatf("%s.c%0d", name, n), obs, exp_q.pop_front());
            @(posedge clock);
            #1;
            n++;
            // Past DECODE the opcode must no longer matter
            if (n == 2) opcode = 6'($urandom);
        end
    endtask

    initial begin
        reset  = 1'b1;
        opcode = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq($sformatf("rst.c%0d", i), obs, v_zero);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_instr("noop0", 6'b000000);
        run_instr("noop1", 6'b000000);

        // Reset asserted in FETCH forces outputs low immediately
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("rst_fetch", obs, v_zero);
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_instr("j",     6'b000001);
        run_instr("beq",   6'b100000);
        run_instr("bne",   6'b100001);
        run_instr("blt",   6'b100010);
        run_instr("addi",  6'b110010);
        run_instr("lui",   6'b111010);
        run_instr("and",   6'b010101);
        run_instr("rtype", 6'b010000);
        run_instr("sw",    6'b111110);
        run_instr("swi",   6'b111100);
        run_instr("lw",    6'b111101);
        run_instr("lwi",   6'b111011);
        run_instr("unk",   6'b101010);
        run_instr("unk2",  6'b111111);

        // LW interrupted by reset while in MEM_RD
        opcode = 6'b111101;
        exp_q.push_back(v_fetch);
        exp_q.push_back(v_decode);
        exp_q.push_back(v_addr_r);
        exp_q.push_back(v_memrd);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq($sformatf("lwrst.c%0d", i), obs, exp_q.pop_front());
            if (i < 3) begin
                @(posedge clock);
                #1;
            end
        end
        reset = 1'b1;
        #1;
        check_eq("lwrst.zero", obs, v_zero);
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_instr("after_rst", 6'b000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
